// File: rtl/adc_spi_reader_pkg.sv
// rtl/adc_spi_reader_pkg.sv - shared ADC constants and reader state encoding
package adc_spi_reader_pkg;

   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_LEAD_BITS  = 4;

   // Bit 0 is set exactly in the states that hold chip select low.
   typedef enum logic [1:0] {
      ADC_ST_IDLE     = 2'b00,
      ADC_ST_CS_SETUP = 2'b01,
      ADC_ST_SHIFT    = 2'b11,
      ADC_ST_QUIET    = 2'b10
   } adc_state_e;

   function automatic logic adc_cs_active(input adc_state_e st);
      return (st == ADC_ST_CS_SETUP) || (st == ADC_ST_SHIFT);
   endfunction

endpackage

// File: rtl/adc_sclk_phase_gen.sv
// rtl/adc_sclk_phase_gen.sv - half-period tick and SCLK level generator
module adc_sclk_phase_gen #(
   parameter int NB_DIV = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [NB_DIV-1:0] div_i,
   input  logic              sclk_run_i,
   output logic              tick_o,
   output logic              sclk_o
);

   logic [NB_DIV-1:0] cnt_q, cnt_d;
   logic              tick_q, tick_d;
   logic              sclk_q, sclk_d;
   logic              wrap;

   // tick_q is registered, so it trails the counter wrap by one cycle.
   always_comb begin
      wrap   = (cnt_q == (div_i - NB_DIV'(1)));
      cnt_d  = '0;
      tick_d = 1'b0;
      if (en_i) begin
         cnt_d  = wrap ? '0 : cnt_q + NB_DIV'(1);
         tick_d = wrap;
      end
      sclk_d = 1'b1;
      if (sclk_run_i) begin
         sclk_d = tick_q ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sclk_q <= sclk_d;
      end
   end

   assign tick_o = tick_q;
   assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - triggered SPI reader for an external serial ADC
module adc_spi_reader
   import adc_spi_reader_pkg::*;
#(
   parameter int NB_DATA    = 12,
   parameter int NB_DIV     = 8,
   parameter int FRAME_BITS = ADC_FRAME_BITS,
   parameter int LEAD_BITS  = ADC_LEAD_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_trigger,
   input  logic [NB_DIV-1:0]  i_clk_div,
   input  logic               i_clr_overrun,
   input  logic               i_adc_sdata,
   output logic               o_adc_cs_n,
   output logic               o_adc_sclk,
   output logic [NB_DATA-1:0] o_adc_val,
   output logic               o_adc_done,
   output logic               o_busy,
   output logic               o_overrun
);

   localparam int HP_W = $clog2(2 * FRAME_BITS);

   if (FRAME_BITS < LEAD_BITS + NB_DATA) begin : g_bad_frame
      $error("adc_spi_reader: FRAME_BITS must be >= LEAD_BITS + NB_DATA");
   end

   adc_state_e         state_q, state_d;
   logic [NB_DIV-1:0]  div_q, div_d;
   logic [HP_W-1:0]    hp_q, hp_d;
   logic [HP_W-1:0]    bit_idx;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic [NB_DATA-1:0] val_q, val_d;
   logic               done_q, done_d;
   logic               ovr_q, ovr_d;
   logic               tick;
   logic               sclk;
   logic               sclk_run;

   adc_sclk_phase_gen #(
      .NB_DIV(NB_DIV)
   ) u_phase (
      .clk        (clk),
      .rst        (rst),
      .en_i       (state_q != ADC_ST_IDLE),
      .div_i      (div_q),
      .sclk_run_i (sclk_run),
      .tick_o     (tick),
      .sclk_o     (sclk)
   );

   assign bit_idx = hp_q >> 1;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hp_d    = hp_q;
      shift_d = shift_q;
      val_d   = val_q;
      done_d  = done_q;
      ovr_d   = ovr_q;

      if (i_clr_overrun) begin
         ovr_d = 1'b0;
      end
      if (i_trigger && (state_q != ADC_ST_IDLE)) begin
         ovr_d = 1'b1;
      end

      unique case (state_q)
         ADC_ST_IDLE: begin
            if (i_trigger) begin
               state_d = ADC_ST_CS_SETUP;
               div_d   = (i_clk_div == '0) ? NB_DIV'(1) : i_clk_div;
               hp_d    = '0;
               shift_d = '0;
               done_d  = 1'b0;
            end
         end
         ADC_ST_CS_SETUP: begin
            if (tick) begin
               state_d = ADC_ST_SHIFT;
            end
         end
         ADC_ST_SHIFT: begin
            if (tick) begin
               // SCLK low at a tick means this edge raises it: sample now.
               if (!sclk && (bit_idx >= HP_W'(LEAD_BITS)) &&
                   (bit_idx < HP_W'(LEAD_BITS + NB_DATA))) begin
                  shift_d = {shift_q[NB_DATA-2:0], i_adc_sdata};
               end
               if (hp_q == HP_W'(2 * FRAME_BITS - 1)) begin
                  state_d = ADC_ST_QUIET;
               end else begin
                  hp_d = hp_q + HP_W'(1);
               end
            end
         end
         ADC_ST_QUIET: begin
            if (tick) begin
               state_d = ADC_ST_IDLE;
               val_d   = shift_q;
               done_d  = 1'b1;
            end
         end
         default: state_d = ADC_ST_IDLE;
      endcase

      sclk_run = (state_d == ADC_ST_SHIFT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ADC_ST_IDLE;
         div_q   <= NB_DIV'(1);
         hp_q    <= '0;
         shift_q <= '0;
         val_q   <= '0;
         done_q  <= 1'b1;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hp_q    <= hp_d;
         shift_q <= shift_d;
         val_q   <= val_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_adc_cs_n = ~adc_cs_active(state_q);
   assign o_adc_sclk = sclk;
   assign o_adc_val  = val_q;
   assign o_adc_done = done_q;
   assign o_busy     = (state_q != ADC_ST_IDLE);
   assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - directed bench for adc_spi_reader with serial ADC model
module tb_adc_spi_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_trigger;
   logic [7:0]  i_clk_div;
   logic        i_clr_overrun;
   logic        i_adc_sdata;
   logic        o_adc_cs_n;
   logic        o_adc_sclk;
   logic [11:0] o_adc_val;
   logic        o_adc_done;
   logic        o_busy;
   logic        o_overrun;

   int total = 0;
   int bad   = 0;

   logic [15:0] adc_word = 16'h0000;
   int          rise_cnt = 0;
   int          fall_cnt = 0;

   always #5 clk = ~clk;

   adc_spi_reader dut (
      .clk           (clk),
      .rst           (rst),
      .i_trigger     (i_trigger),
      .i_clk_div     (i_clk_div),
      .i_clr_overrun (i_clr_overrun),
      .i_adc_sdata   (i_adc_sdata),
      .o_adc_cs_n    (o_adc_cs_n),
      .o_adc_sclk    (o_adc_sclk),
      .o_adc_val     (o_adc_val),
      .o_adc_done    (o_adc_done),
      .o_busy        (o_busy),
      .o_overrun     (o_overrun)
   );

   // ADC model: presents the next MSB-first frame bit after each SCLK rise.
   always @(posedge o_adc_sclk or posedge o_adc_cs_n) begin
      if (o_adc_cs_n) rise_cnt <= 0;
      else            rise_cnt <= rise_cnt + 1;
   end

   always @(negedge o_adc_sclk) begin
      if (!o_adc_cs_n) fall_cnt = fall_cnt + 1;
   end

   assign i_adc_sdata = (rise_cnt < 16) ? adc_word[15 - rise_cnt] : 1'b0;

   typedef struct {
      logic [7:0]  div;
      logic [15:0] word;
      logic [11:0] exp_val;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_trigger();
      i_trigger = 1'b1;
      @(posedge clk);
      #1;
      i_trigger = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!o_adc_done && lat < 10000) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int lat;

   initial begin
      vecs[0] = '{8'd4,   16'h0ABC, 12'hABC, 137};
      vecs[1] = '{8'd0,   16'h0123, 12'h123, 35};
      vecs[2] = '{8'd1,   16'h0555, 12'h555, 35};
      vecs[3] = '{8'd2,   16'h0AAA, 12'hAAA, 69};
      vecs[4] = '{8'd3,   16'hF5A3, 12'h5A3, 103};
      vecs[5] = '{8'd255, 16'h0C3A, 12'hC3A, 8671};

      rst           = 1'b0;
      i_trigger     = 1'b0;
      i_clk_div     = 8'd4;
      i_clr_overrun = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", o_adc_cs_n, 1);
      check("rst_sclk", o_adc_sclk, 1);
      check("rst_val", o_adc_val, 0);
      check("rst_done", o_adc_done, 1);
      check("rst_busy", o_busy, 0);
      check("rst_ovr", o_overrun, 0);
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a D=4 frame
      adc_word = 16'h0ABC;
      @(negedge clk);
      i_clk_div = 8'd4;
      pulse_trigger();
      check("trig_done_low", o_adc_done, 0);
      check("trig_busy", o_busy, 1);
      repeat (60) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_cs_n", o_adc_cs_n, 1);
      check("abort_sclk", o_adc_sclk, 1);
      check("abort_done", o_adc_done, 1);
      check("abort_busy", o_busy, 0);
      check("abort_val", o_adc_val, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         i_clk_div = vecs[i].div;
         adc_word  = vecs[i].word;
         fall_cnt  = 0;
         pulse_trigger();
         wait_done(lat);
         check($sformatf("vec%0d_val", i), o_adc_val, vecs[i].exp_val);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_falls", i), fall_cnt, 16);
      end

      // Overrun: retrigger while busy, then set and clear together
      @(negedge clk);
      i_clk_div = 8'd4;
      adc_word  = 16'h0ABC;
      fall_cnt  = 0;
      pulse_trigger();
      repeat (9) @(posedge clk);
      #1;
      pulse_trigger();
      check("ovr_set", o_overrun, 1);
      check("ovr_busy", o_busy, 1);
      repeat (10) @(posedge clk);
      #1;
      i_clr_overrun = 1'b1;
      pulse_trigger();
      i_clr_overrun = 1'b0;
      check("ovr_set_wins", o_overrun, 1);
      wait_done(lat);
      check("ovr_lat", lat, 116);
      check("ovr_val", o_adc_val, 12'hABC);
      check("ovr_falls", fall_cnt, 16);
      repeat (40) @(posedge clk);
      #1;
      check("ovr_one_frame_busy", o_busy, 0);
      check("ovr_one_frame_falls", fall_cnt, 16);
      check("ovr_sticky", o_overrun, 1);
      i_clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      i_clr_overrun = 1'b0;
      check("ovr_clear", o_overrun, 0);

      // Back-to-back conversions
      @(negedge clk);
      i_clk_div = 8'd2;
      adc_word  = 16'h0FFF;
      fall_cnt  = 0;
      pulse_trigger();
      wait_done(lat);
      check("b2b_val0", o_adc_val, 12'hFFF);
      check("b2b_lat0", lat, 69);
      adc_word = 16'h0001;
      fall_cnt = 0;
      pulse_trigger();
      check("b2b_accept_done", o_adc_done, 0);
      check("b2b_accept_busy", o_busy, 1);
      check("b2b_hold_val", o_adc_val, 12'hFFF);
      wait_done(lat);
      check("b2b_val1", o_adc_val, 12'h001);
      check("b2b_lat1", lat, 69);
      check("b2b_falls1", fall_cnt, 16);
      check("b2b_no_ovr", o_overrun, 0);

      // Divider change mid-frame is ignored
      @(negedge clk);
      i_clk_div = 8'd4;
      adc_word  = 16'h0321;
      fall_cnt  = 0;
      pulse_trigger();
      repeat (30) @(posedge clk);
      #1;
      i_clk_div = 8'd2;
      wait_done(lat);
      check("div_chg_lat", lat, 107);
      check("div_chg_val", o_adc_val, 12'h321);
      check("div_chg_falls", fall_cnt, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
